// File: rtl/mmss_time_core.sv
// MM:SS timekeeping core: BCD minutes/seconds with run/pause/adjust control,
// feeding four registered active-low seven-segment digit codes.
module mmss_time_core #(
  parameter int MAX_MIN = 59,
  parameter int MAX_SEC = 59
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1hz,
  input  logic       tick_2hz,
  input  logic       pause_btn,
  input  logic       clr,
  input  logic       adj,
  input  logic       sel,
  output logic [6:0] tens_minutes,
  output logic [6:0] ones_minutes,
  output logic [6:0] tens_seconds,
  output logic [6:0] ones_seconds,
  output logic       running,
  output logic       wrap
);

  typedef enum logic [1:0] {PAUSE, RUN, ADJ} state_t;

  localparam logic [7:0] MinMaxBcd = {4'(MAX_MIN / 10), 4'(MAX_MIN % 10)};
  localparam logic [7:0] SecMaxBcd = {4'(MAX_SEC / 10), 4'(MAX_SEC % 10)};
  localparam logic [6:0] SegZero   = 7'b1000000;
  localparam logic [6:0] SegBlank  = 7'b1111111;

  state_t     state_q, state_d;
  logic [7:0] minutes_q, minutes_d;
  logic [7:0] seconds_q, seconds_d;
  logic       phase_q, phase_d;
  logic       wrap_q, wrap_d;
  logic [6:0] tensMinutes_q, onesMinutes_q, tensSeconds_q, onesSeconds_q;
  logic       running_q;
  logic       blankMinutes, blankSeconds;

  // Two-digit BCD increment that wraps the field maximum back to 00.
  function automatic logic [7:0] bcdInc(input logic [7:0] value, input logic [7:0] maxValue);
    logic [7:0] result;
    if (value == maxValue)
      result = 8'h00;
    else if (value[3:0] == 4'd9)
      result = {value[7:4] + 4'd1, 4'd0};
    else
      result = {value[7:4], value[3:0] + 4'd1};
    return result;
  endfunction

  function automatic logic [6:0] segEncode(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = 7'b1111111;
    endcase
    return seg;
  endfunction

  // Next-state logic: adj outranks pause_btn, clr outranks any increment.
  always_comb begin
    state_d   = state_q;
    minutes_d = minutes_q;
    seconds_d = seconds_q;
    phase_d   = phase_q;
    wrap_d    = 1'b0;
    case (state_q)
      PAUSE: begin
        if (adj)            state_d = ADJ;
        else if (pause_btn) state_d = RUN;
      end
      RUN: begin
        if (adj)            state_d = ADJ;
        else if (pause_btn) state_d = PAUSE;
        if (tick_1hz) begin
          if (seconds_q == SecMaxBcd) begin
            seconds_d = 8'h00;
            minutes_d = bcdInc(minutes_q, MinMaxBcd);
            wrap_d    = (minutes_q == MinMaxBcd);
          end else begin
            seconds_d = bcdInc(seconds_q, SecMaxBcd);
          end
        end
      end
      ADJ: begin
        if (!adj) state_d = PAUSE;
        if (tick_2hz) begin
          phase_d = ~phase_q;
          if (sel) seconds_d = bcdInc(seconds_q, SecMaxBcd);
          else     minutes_d = bcdInc(minutes_q, MinMaxBcd);
        end
      end
      default: state_d = PAUSE;
    endcase
    if (clr) begin
      minutes_d = 8'h00;
      seconds_d = 8'h00;
      wrap_d    = 1'b0;
    end
    // Phase restarts at 0 on every entry to ADJ and is held at 0 elsewhere.
    if (state_d != ADJ || state_q != ADJ) phase_d = (state_q == ADJ && state_d == ADJ) ? phase_d : 1'b0;
  end

  assign blankMinutes = (state_q == ADJ) && phase_q && !sel;
  assign blankSeconds = (state_q == ADJ) && phase_q && sel;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= PAUSE;
      minutes_q     <= 8'h00;
      seconds_q     <= 8'h00;
      phase_q       <= 1'b0;
      wrap_q        <= 1'b0;
      tensMinutes_q <= SegZero;
      onesMinutes_q <= SegZero;
      tensSeconds_q <= SegZero;
      onesSeconds_q <= SegZero;
      running_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      minutes_q     <= minutes_d;
      seconds_q     <= seconds_d;
      phase_q       <= phase_d;
      wrap_q        <= wrap_d;
      // Display stage lags the count/state registers by one cycle.
      tensMinutes_q <= blankMinutes ? SegBlank : segEncode(minutes_q[7:4]);
      onesMinutes_q <= blankMinutes ? SegBlank : segEncode(minutes_q[3:0]);
      tensSeconds_q <= blankSeconds ? SegBlank : segEncode(seconds_q[7:4]);
      onesSeconds_q <= blankSeconds ? SegBlank : segEncode(seconds_q[3:0]);
      running_q     <= (state_q == RUN);
    end
  end

  assign tens_minutes = tensMinutes_q;
  assign ones_minutes = onesMinutes_q;
  assign tens_seconds = tensSeconds_q;
  assign ones_seconds = onesSeconds_q;
  assign running      = running_q;
  assign wrap         = wrap_q;

endmodule

// File: tb/tb_mmss_time_core.sv
// Directed bench for mmss_time_core: run/pause, wrap, adjust with blink,
// clr priority, adj/pause priority and mid-adjust reset.
module tb_mmss_time_core;

  localparam logic [6:0] Seg0 = 7'b1000000;
  localparam logic [6:0] Seg1 = 7'b1111001;
  localparam logic [6:0] Seg2 = 7'b0100100;
  localparam logic [6:0] Seg3 = 7'b0110000;
  localparam logic [6:0] Seg4 = 7'b0011001;
  localparam logic [6:0] Seg5 = 7'b0010010;
  localparam logic [6:0] Seg8 = 7'b0000000;
  localparam logic [6:0] Seg9 = 7'b0010000;
  localparam logic [6:0] SegBlank = 7'b1111111;

  logic clk = 1'b0;
  logic reset, tick1hz, tick2hz, pauseBtn, clr, adj, sel;
  logic [6:0] tensMinutes, onesMinutes, tensSeconds, onesSeconds;
  logic running, wrap;
  int checks = 0;
  int errors = 0;

  mmss_time_core #(.MAX_MIN(59), .MAX_SEC(59)) dut (
    .clk(clk), .reset(reset), .tick_1hz(tick1hz), .tick_2hz(tick2hz),
    .pause_btn(pauseBtn), .clr(clr), .adj(adj), .sel(sel),
    .tens_minutes(tensMinutes), .ones_minutes(onesMinutes),
    .tens_seconds(tensSeconds), .ones_seconds(onesSeconds),
    .running(running), .wrap(wrap)
  );

  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Drives the given one-cycle pulses across exactly one active edge.
  task automatic applyStimulus(input logic t1, input logic t2, input logic pb, input logic c);
    tick1hz = t1; tick2hz = t2; pauseBtn = pb; clr = c;
    cycle();
    tick1hz = 1'b0; tick2hz = 1'b0; pauseBtn = 1'b0; clr = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [6:0] observed, input logic [6:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
    end
  endtask

  initial begin
    reset = 1'b1; tick1hz = 1'b0; tick2hz = 1'b0; pauseBtn = 1'b0;
    clr = 1'b0; adj = 1'b0; sel = 1'b0;
    cycle(); cycle();
    reset = 1'b0;
    checkOutput("reset_tm", tensMinutes, Seg0);
    checkOutput("reset_om", onesMinutes, Seg0);
    checkOutput("reset_ts", tensSeconds, Seg0);
    checkOutput("reset_os", onesSeconds, Seg0);
    checkOutput("reset_running", {6'b0, running}, 7'd0);
    checkOutput("reset_wrap", {6'b0, wrap}, 7'd0);

    // Run and count five seconds.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    cycle();
    checkOutput("run5_os", onesSeconds, Seg5);
    checkOutput("run5_ts", tensSeconds, Seg0);
    checkOutput("run5_om", onesMinutes, Seg0);
    checkOutput("run5_tm", tensMinutes, Seg0);
    checkOutput("run5_running", {6'b0, running}, 7'd1);

    // Preload 59:58 through adjust mode (00:05 -> minutes +59, seconds +53).
    adj = 1'b1; sel = 1'b0;
    cycle();
    for (int i = 0; i < 59; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    sel = 1'b1;
    for (int i = 0; i < 53; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    adj = 1'b0;
    cycle(); cycle();
    checkOutput("pre_tm", tensMinutes, Seg5);
    checkOutput("pre_om", onesMinutes, Seg9);
    checkOutput("pre_ts", tensSeconds, Seg5);
    checkOutput("pre_os", onesSeconds, Seg8);
    checkOutput("pre_running", {6'b0, running}, 7'd0);

    // Run through 59:59 into the full wrap.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("wrap_early", {6'b0, wrap}, 7'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("wrap_pulse", {6'b0, wrap}, 7'd1);
    cycle();
    checkOutput("wrap_cleared", {6'b0, wrap}, 7'd0);
    checkOutput("wrap_tm", tensMinutes, Seg0);
    checkOutput("wrap_om", onesMinutes, Seg0);
    checkOutput("wrap_ts", tensSeconds, Seg0);
    checkOutput("wrap_os", onesSeconds, Seg0);
    checkOutput("wrap_running", {6'b0, running}, 7'd1);

    // 00:59, then adjust seconds once: field wraps, no carry, seconds blink.
    for (int i = 0; i < 59; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    adj = 1'b1; sel = 1'b1;
    cycle();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("adj_wrap", {6'b0, wrap}, 7'd0);
    cycle();
    checkOutput("adj_ts_blank", tensSeconds, SegBlank);
    checkOutput("adj_os_blank", onesSeconds, SegBlank);
    checkOutput("adj_tm", tensMinutes, Seg0);
    checkOutput("adj_om", onesMinutes, Seg0);
    checkOutput("adj_running", {6'b0, running}, 7'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    sel = 1'b0;
    cycle();
    checkOutput("adj_sel_tm_blank", tensMinutes, SegBlank);
    checkOutput("adj_sel_os", onesSeconds, Seg0);

    // clr beats a simultaneous tick in RUN.
    adj = 1'b0;
    cycle();
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    cycle();
    checkOutput("clr_os", onesSeconds, Seg0);
    checkOutput("clr_running", {6'b0, running}, 7'd1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    cycle();
    checkOutput("clr_next_os", onesSeconds, Seg1);

    // adj beats pause_btn; exiting ADJ pauses.
    adj = 1'b1; pauseBtn = 1'b1;
    cycle();
    pauseBtn = 1'b0;
    cycle();
    checkOutput("prio_running", {6'b0, running}, 7'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    cycle();
    checkOutput("prio_tm_blank", tensMinutes, SegBlank);
    adj = 1'b0;
    cycle(); cycle();
    checkOutput("exit_running", {6'b0, running}, 7'd0);
    checkOutput("exit_om", onesMinutes, Seg1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    cycle();
    checkOutput("exit_os_hold", onesSeconds, Seg1);

    // Adjust 01:01 to 12:34, then reset mid-adjust.
    adj = 1'b1; sel = 1'b0;
    cycle();
    for (int i = 0; i < 11; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    sel = 1'b1;
    for (int i = 0; i < 33; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    cycle();
    checkOutput("set_tm", tensMinutes, Seg1);
    checkOutput("set_om", onesMinutes, Seg2);
    checkOutput("set_ts", tensSeconds, Seg3);
    checkOutput("set_os", onesSeconds, Seg4);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    reset = 1'b1; adj = 1'b0;
    cycle();
    reset = 1'b0;
    checkOutput("rst_tm", tensMinutes, Seg0);
    checkOutput("rst_om", onesMinutes, Seg0);
    checkOutput("rst_ts", tensSeconds, Seg0);
    checkOutput("rst_os", onesSeconds, Seg0);
    checkOutput("rst_running", {6'b0, running}, 7'd0);
    cycle();
    checkOutput("rst_hold_os", onesSeconds, Seg0);
    checkOutput("rst_hold_ts", tensSeconds, Seg0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
